// File: rtl/uart_phy_pkg.sv
// Shared definitions for the UART physical layer: FSM state encoding and frame constants.
// Both the receive deserialiser and the transmit serialiser walk the same four states.
package uart_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned DATA_BITS    = 8;
    localparam logic [2:0]  LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserialiser: input synchroniser, RX FSM, single-byte holding register
// and one-cycle frame-error / overrun pulses.
module uart_rx_deser
    import uart_phy_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       m_aresetn,
    input  logic       uart_rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned         CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q, sync_d;
    logic             rxs_prev_q, rxs_prev_d;
    logic             rxs;
    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             bit_done;
    logic             holding_free;

    assign rxs          = sync_q[1];
    assign bit_done     = (cnt_q == CNT_ONE);
    assign holding_free = !valid_q || rx_ready;

    // Synchroniser shift and previous-sample tracking for falling-edge detection.
    always_comb begin
        sync_d     = {sync_q[0], uart_rxd};
        rxs_prev_d = rxs;
    end

    // Synchroniser state; resets to the idle-high line level so reset never looks like a start edge.
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            rxs_prev_q <= rxs_prev_d;
        end
    end

    // RX FSM next state, bit sampling and holding-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    // A line that is already high again mid-start-bit was only a glitch.
                    if (!rxs) begin
                        state_d = ST_DATA;
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = CNT_FULL;
                    if (idx_q == LAST_BIT_IDX) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    // Returning to IDLE mid-stop-bit lets the next start edge follow with no gap.
                    state_d = ST_IDLE;
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end else if (holding_free) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RX FSM, counter, shift and holding registers.
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_valid     = valid_q;
    assign rx_data      = data_q;
    assign rx_frame_err = ferr_q;
    assign rx_overrun   = ovr_q;

endmodule

// File: rtl/uart_phy.sv
// Byte-level UART 8N1 PHY: RX deserialiser instance plus an inline TX serialiser,
// each on its own valid/ready stream and fully independent.
module uart_phy
    import uart_phy_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       m_aresetn,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready
);

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    uart_rx_deser #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .m_aresetn    (m_aresetn),
        .uart_rxd     (uart_rxd),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    uart_state_e      tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             txd_q, txd_d;
    logic             tx_ready_q, tx_ready_d;
    logic             tx_bit_done;

    assign tx_bit_done = (tx_cnt_q == CNT_ONE);

    // TX FSM next state and next line level; the line register changes on the same edge as the state.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;

        case (tx_state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    tx_state_d = ST_START;
                    tx_shift_d = tx_data;
                    tx_cnt_d   = CNT_FULL;
                    txd_d      = 1'b0;
                end else begin
                    txd_d = 1'b1;
                end
            end
            ST_START: begin
                if (tx_bit_done) begin
                    tx_state_d = ST_DATA;
                    tx_cnt_d   = CNT_FULL;
                    tx_idx_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_bit_done) begin
                    tx_cnt_d = CNT_FULL;
                    if (tx_idx_q == LAST_BIT_IDX) begin
                        tx_state_d = ST_STOP;
                        txd_d      = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_bit_done) begin
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q - CNT_ONE;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                txd_d      = 1'b1;
            end
        endcase

        tx_ready_d = (tx_state_d == ST_IDLE);
    end

    // TX FSM, counter, shift register and registered line/ready outputs.
    always_ff @(posedge clk or negedge m_aresetn) begin
        if (!m_aresetn) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            tx_ready_q <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
            tx_ready_q <= tx_ready_d;
        end
    end

    assign uart_txd = txd_q;
    assign tx_ready = tx_ready_q;

endmodule
